udp_tx_framer: RTL and testbench
================================

# udp_tx_framer

Client-side UDP transmit framer for the 10G TCP/UDP stack. It accepts a 64-bit word stream from application logic and buffers one complete frame in local RAM. It then plays that frame into the stack's UDP transmit port using the start/end-of-frame and byte-valid convention, and holds the frame until the stack acknowledges it. On NAK or timeout it replays the frame up to a retry limit. It sits between a data source (ADC/event builder) and the stack wrapper's udp_tx_* ports.

## Interface
Parameters:
- MAX_WORDS, 128: frame buffer depth in 64-bit words (power of 2, 8..1024); longest frame = MAX_WORDS*8 bytes
- MAX_RETRY, 3: replays after NAK/timeout before the frame is dropped
- ACK_TIMEOUT, 65535: cycles spent in WAIT_ACK before the frame counts as a NAK

Ports:
- clk  in  1  single clock domain
- sync_reset  in  1  synchronous, active-high reset
- s_data  in  64  input word; byte 0 in bits 63:56
- s_keep  in  8  byte mask, used on the last word only; MSB-contiguous (8'hF0 = 4 bytes)
- s_valid  in  1  input word valid
- s_last  in  1  last word of frame
- s_ready  out  1  framer accepts the word this cycle
- cfg_dest_ip_addr  in  128  destination IP; sampled on the first word of each frame
- cfg_dest_ipv4_6n  in  1  1 = IPv4; sampled with the destination IP
- cfg_dest_port_no  in  16  destination port; sampled with the destination IP
- cfg_source_port_no  in  16  source port; sampled with the destination IP
- udp_tx_data  out  64  to stack
- udp_tx_data_valid  out  8  byte valid; 8'h00 = no word
- udp_tx_sof  out  1  first word of frame
- udp_tx_eof  out  1  last word of frame
- udp_tx_cts  in  1  stack accepts the word this cycle
- udp_tx_ack  in  1  one-cycle pulse, frame sent
- udp_tx_nak  in  1  one-cycle pulse, frame rejected (e.g. ARP pending)
- udp_tx_dest_ip_addr  out  128  latched copy of cfg_dest_ip_addr
- udp_tx_dest_ipv4_6n  out  1  latched copy of cfg_dest_ipv4_6n
- udp_tx_dest_port_no  out  16  latched copy of cfg_dest_port_no
- udp_tx_source_port_no  out  16  latched copy of cfg_source_port_no
- frames_sent  out  32  count of ACKed frames, wraps
- frames_dropped  out  32  count of frames dropped after retries, wraps
- busy  out  1  high in every state except FILL

## Operation
- The state machine has four states: FILL, SEND, WAIT_ACK, DROP.
- FILL:
  - s_ready = 1. Each accepted word is written at wr_ptr, and wr_ptr increments.
  - The first accepted word of a frame latches the cfg_* inputs into the udp_tx_dest/source outputs.
  - The frame closes on an accepted word with s_last = 1. It also closes when wr_ptr reaches MAX_WORDS-1; in that case the forced word gets keep 8'hFF, and the source's remaining words start a new frame.
  - On close: last_idx ← wr_ptr, last_keep ← s_keep (8'hFF if forced), wr_ptr ← 0, retry ← 0, next state SEND.
  - s_keep on non-last words is ignored and treated as 8'hFF.
- SEND:
  - s_ready = 0. The framer presents word rd_ptr.
  - udp_tx_sof = (rd_ptr == 0). udp_tx_eof = (rd_ptr == last_idx).
  - udp_tx_data_valid = last_keep on the EOF word, 8'hFF on every other word.
  - A word transfers only in a cycle with data_valid ≠ 0 and udp_tx_cts = 1. With cts = 0, the presented word, sof and eof are held unchanged.
  - The EOF transfer sets rd_ptr ← 0 and moves to WAIT_ACK.
- WAIT_ACK:
  - Outputs idle: data_valid = 0, sof = 0, eof = 0.
  - ack → frames_sent + 1, next state FILL.
  - nak, or timer reaching ACK_TIMEOUT → if retry < MAX_RETRY, then retry + 1 and go to SEND (full replay from word 0); otherwise go to DROP.
  - ack and nak in the same cycle: ack wins.
  - ack/nak seen in FILL or SEND are ignored.
- DROP: frames_dropped + 1, next state FILL. Lasts one cycle.
- udp_tx_dest/source outputs stay constant from SEND until the next frame's first word is accepted.
- A single-word frame has sof and eof high together.

## Timing
- Reset applies on the first rising edge with sync_reset = 1; an in-flight frame is discarded without counting. Reset values:
  - state FILL, all pointers and counters 0, frames_sent = 0, frames_dropped = 0
  - udp_tx_* outputs all 0; s_ready = 1 one cycle after reset deasserts; busy = 0
- All outputs are registered except s_ready, which decodes state.
- RAM read latency is one cycle, so SEND must prefetch:
  - First word is presented 2 cycles after the closing word is accepted.
  - With cts held high, transfer is one word per cycle with no bubbles.
  - A cts drop must never lose or duplicate a word.
- Replay: first word is presented 2 cycles after the nak/timeout cycle.
- ACK → s_ready = 1 on the next cycle.
- The timeout timer clears when WAIT_ACK is entered and counts each cycle spent there. It is 16 bits minimum, sized to hold ACK_TIMEOUT.

## Test plan
- 3-word frame, keep 8'hC0, cts held 1, ack 5 cycles after eof → output words 0,1,2 with valid FF, FF, C0; sof on word 0, eof on word 2; frames_sent = 1.
- Same frame with cts toggled 1,0,0,1,0,1 → identical 3-word sequence, each word transferred exactly once, data held during cts = 0.
- nak ×2 then ack → frame transmitted 3 times, byte-identical each time; frames_sent = 1, frames_dropped = 0.
- nak ×4 with MAX_RETRY = 3 → 4 transmissions then DROP; frames_dropped = 1; s_ready high again.
- 130 words with s_last on the last word, MAX_WORDS = 128 → a 128-word frame with eof on word 127, valid FF; then a 2-word frame. cfg_dest_port_no changed mid-fill is not applied until the second frame.
- sync_reset asserted mid-SEND at word 5 → next cycle: data_valid = 0, counters 0, s_ready = 1. A new 1-word frame then emits with sof and eof both high.

Source files
------------

// File: rtl/udp_tx_framer_if.sv
// udp_tx_framer_if: UDP transmit bus between the framer and the stack wrapper.
//
// Handshake: a word moves from master to slave in a cycle where
// udp_tx_data_valid != 8'h00 and udp_tx_cts = 1. While cts = 0 the master
// holds data, data_valid, sof and eof unchanged. ack/nak are one-cycle
// pulses from the slave that report the outcome of the whole frame.
//
// Signals:
//   udp_tx_data            64   word, byte 0 in bits 63:56
//   udp_tx_data_valid      8    byte valid, 8'h00 = no word
//   udp_tx_sof/eof         1    first/last word of frame
//   udp_tx_cts             1    slave accepts the word this cycle
//   udp_tx_ack/nak         1    frame sent / frame rejected
//   udp_tx_dest_*/source_* header fields held for the current frame
interface udp_tx_framer_if;
    logic [63:0]  udp_tx_data;
    logic [7:0]   udp_tx_data_valid;
    logic         udp_tx_sof;
    logic         udp_tx_eof;
    logic         udp_tx_cts;
    logic         udp_tx_ack;
    logic         udp_tx_nak;
    logic [127:0] udp_tx_dest_ip_addr;
    logic         udp_tx_dest_ipv4_6n;
    logic [15:0]  udp_tx_dest_port_no;
    logic [15:0]  udp_tx_source_port_no;

    modport master (
        output udp_tx_data, udp_tx_data_valid, udp_tx_sof, udp_tx_eof,
               udp_tx_dest_ip_addr, udp_tx_dest_ipv4_6n,
               udp_tx_dest_port_no, udp_tx_source_port_no,
        input  udp_tx_cts, udp_tx_ack, udp_tx_nak
    );

    modport slave (
        input  udp_tx_data, udp_tx_data_valid, udp_tx_sof, udp_tx_eof,
               udp_tx_dest_ip_addr, udp_tx_dest_ipv4_6n,
               udp_tx_dest_port_no, udp_tx_source_port_no,
        output udp_tx_cts, udp_tx_ack, udp_tx_nak
    );
endinterface

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: buffers one frame of 64-bit words from a source, plays it
// into the stack's UDP transmit port and replays it on NAK/timeout until a
// retry limit, after which the frame is dropped.
//
// Ports:
//   clk, sync_reset          clock, synchronous active-high reset
//   s_data/s_keep/s_valid/s_last/s_ready   input word stream (s_ready = FILL)
//   cfg_*                    header fields, sampled on a frame's first word
//   udp_tx                   master side of the UDP transmit bus
//   frames_sent/dropped      wrapping frame counters
//   busy                     high in every state except FILL
//   state_dbg                current FSM state (FILL=0 SEND=1 WAIT_ACK=2 DROP=3)
module udp_tx_framer #(
    parameter int MAX_WORDS   = 128,
    parameter int MAX_RETRY   = 3,
    parameter int ACK_TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   sync_reset,
    input  logic [63:0]            s_data,
    input  logic [7:0]             s_keep,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    input  logic [127:0]           cfg_dest_ip_addr,
    input  logic                   cfg_dest_ipv4_6n,
    input  logic [15:0]            cfg_dest_port_no,
    input  logic [15:0]            cfg_source_port_no,
    udp_tx_framer_if.master        udp_tx,
    output logic [31:0]            frames_sent,
    output logic [31:0]            frames_dropped,
    output logic                   busy,
    output logic [1:0]             state_dbg
);
    localparam int AW = $clog2(MAX_WORDS);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW = ($clog2(ACK_TIMEOUT + 1) > 16) ? $clog2(ACK_TIMEOUT + 1) : 16;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2,
        DROP     = 2'd3
    } state_t;

    state_t          state;
    logic [63:0]     mem [MAX_WORDS];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   last_idx;
    logic [7:0]      last_keep;
    logic [RW-1:0]   retry;
    logic [TW-1:0]   timer;
    logic            accept;
    logic            close;
    logic            presented;

    assign s_ready   = (state == FILL);
    assign state_dbg = state;
    assign accept    = s_valid && s_ready;
    // A frame closes on s_last or when the buffer is full.
    assign close     = accept && (s_last || (wr_ptr == AW'(MAX_WORDS - 1)));
    assign presented = (udp_tx.udp_tx_data_valid != 8'h00);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state                        <= FILL;
            wr_ptr                       <= '0;
            rd_ptr                       <= '0;
            last_idx                     <= '0;
            last_keep                    <= 8'h00;
            retry                        <= '0;
            timer                        <= '0;
            frames_sent                  <= 32'd0;
            frames_dropped               <= 32'd0;
            busy                         <= 1'b0;
            udp_tx.udp_tx_data           <= 64'd0;
            udp_tx.udp_tx_data_valid     <= 8'h00;
            udp_tx.udp_tx_sof            <= 1'b0;
            udp_tx.udp_tx_eof            <= 1'b0;
            udp_tx.udp_tx_dest_ip_addr   <= 128'd0;
            udp_tx.udp_tx_dest_ipv4_6n   <= 1'b0;
            udp_tx.udp_tx_dest_port_no   <= 16'd0;
            udp_tx.udp_tx_source_port_no <= 16'd0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        if (wr_ptr == '0) begin
                            udp_tx.udp_tx_dest_ip_addr   <= cfg_dest_ip_addr;
                            udp_tx.udp_tx_dest_ipv4_6n   <= cfg_dest_ipv4_6n;
                            udp_tx.udp_tx_dest_port_no   <= cfg_dest_port_no;
                            udp_tx.udp_tx_source_port_no <= cfg_source_port_no;
                        end
                        if (close) begin
                            last_idx  <= wr_ptr;
                            last_keep <= s_last ? s_keep : 8'hFF;
                            wr_ptr    <= '0;
                            rd_ptr    <= '0;
                            retry     <= '0;
                            busy      <= 1'b1;
                            state     <= SEND;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                SEND: begin
                    // The output register doubles as the RAM read register:
                    // it reloads when empty or when its word transfers, and
                    // holds otherwise, so a cts drop never loses a word.
                    if (presented && udp_tx.udp_tx_cts && udp_tx.udp_tx_eof) begin
                        udp_tx.udp_tx_data_valid <= 8'h00;
                        udp_tx.udp_tx_sof        <= 1'b0;
                        udp_tx.udp_tx_eof        <= 1'b0;
                        rd_ptr                   <= '0;
                        timer                    <= '0;
                        state                    <= WAIT_ACK;
                    end else if (!presented || udp_tx.udp_tx_cts) begin
                        udp_tx.udp_tx_data       <= mem[rd_ptr];
                        udp_tx.udp_tx_sof        <= (rd_ptr == '0);
                        udp_tx.udp_tx_eof        <= (rd_ptr == last_idx);
                        udp_tx.udp_tx_data_valid <= (rd_ptr == last_idx) ? last_keep : 8'hFF;
                        rd_ptr                   <= rd_ptr + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    timer <= timer + 1'b1;
                    if (udp_tx.udp_tx_ack) begin
                        frames_sent <= frames_sent + 32'd1;
                        busy        <= 1'b0;
                        state       <= FILL;
                    end else if (udp_tx.udp_tx_nak || (timer == TW'(ACK_TIMEOUT))) begin
                        if (retry < RW'(MAX_RETRY)) begin
                            retry <= retry + 1'b1;
                            state <= SEND;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                DROP: begin
                    frames_dropped <= frames_dropped + 32'd1;
                    busy           <= 1'b0;
                    state          <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_tx_framer.sv
module tb_udp_tx_framer;
    localparam int MAX_WORDS   = 128;
    localparam int MAX_RETRY   = 3;
    localparam int ACK_TIMEOUT = 40;

    logic         clk = 1'b0;
    logic         sync_reset;
    logic [63:0]  s_data;
    logic [7:0]   s_keep;
    logic         s_valid;
    logic         s_last;
    logic         s_ready;
    logic [127:0] cfg_dest_ip_addr;
    logic         cfg_dest_ipv4_6n;
    logic [15:0]  cfg_dest_port_no;
    logic [15:0]  cfg_source_port_no;
    logic [31:0]  frames_sent;
    logic [31:0]  frames_dropped;
    logic         busy;
    logic [1:0]   state_dbg;

    udp_tx_framer_if u_if();

    udp_tx_framer #(
        .MAX_WORDS(MAX_WORDS), .MAX_RETRY(MAX_RETRY), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .sync_reset(sync_reset),
        .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready),
        .cfg_dest_ip_addr(cfg_dest_ip_addr), .cfg_dest_ipv4_6n(cfg_dest_ipv4_6n),
        .cfg_dest_port_no(cfg_dest_port_no), .cfg_source_port_no(cfg_source_port_no),
        .udp_tx(u_if),
        .frames_sent(frames_sent), .frames_dropped(frames_dropped),
        .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int exp_sent = 0;
    int exp_dropped = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  expv_q[$];
    logic [1:0]  expf_q[$];
    logic [63:0] got_d[$];
    logic [7:0]  got_v[$];
    logic [1:0]  got_f[$];
    logic [15:0] port_q[$];
    int          sof_cyc_q[$];
    int          eof_cyc_q[$];
    int          tx_count = 0;
    int          hold_err = 0;
    int          ack_cyc = -10;

    // ---------------- stack model + monitor ----------------
    int       naks_left = 0;
    int       silent_left = 0;
    int       resp_cnt = 0;
    int       ack_delay = 5;
    bit       cts_toggle = 1'b0;
    int       cts_idx = 0;
    bit [5:0] cts_pat = 6'b100101;   // 1,0,0,1,0,1 MSB first

    logic        prev_stall = 1'b0;
    logic [63:0] prev_d;
    logic [7:0]  prev_v;
    logic [1:0]  prev_f;

    initial begin
        u_if.udp_tx_cts = 1'b1;
        u_if.udp_tx_ack = 1'b0;
        u_if.udp_tx_nak = 1'b0;
        forever begin
            @(negedge clk);
            if (u_if.udp_tx_ack) ack_cyc = cyc;
            if (prev_stall && (u_if.udp_tx_data !== prev_d || u_if.udp_tx_data_valid !== prev_v ||
                               {u_if.udp_tx_sof, u_if.udp_tx_eof} !== prev_f))
                hold_err++;
            prev_stall = (u_if.udp_tx_data_valid != 8'h00) && !u_if.udp_tx_cts;
            prev_d = u_if.udp_tx_data;
            prev_v = u_if.udp_tx_data_valid;
            prev_f = {u_if.udp_tx_sof, u_if.udp_tx_eof};
            if (u_if.udp_tx_data_valid != 8'h00 && u_if.udp_tx_cts) begin
                got_d.push_back(u_if.udp_tx_data);
                got_v.push_back(u_if.udp_tx_data_valid);
                got_f.push_back({u_if.udp_tx_sof, u_if.udp_tx_eof});
                if (u_if.udp_tx_sof) begin
                    tx_count++;
                    sof_cyc_q.push_back(cyc);
                    port_q.push_back(u_if.udp_tx_dest_port_no);
                end
                if (u_if.udp_tx_eof) begin
                    eof_cyc_q.push_back(cyc);
                    if (silent_left > 0) silent_left--;
                    else resp_cnt = ack_delay;
                end
            end
            @(posedge clk);
            #1;
            u_if.udp_tx_cts = cts_toggle ? cts_pat[5 - (cts_idx % 6)] : 1'b1;
            cts_idx++;
            u_if.udp_tx_ack = 1'b0;
            u_if.udp_tx_nak = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    if (naks_left > 0) begin
                        u_if.udp_tx_nak = 1'b1;
                        naks_left--;
                    end else begin
                        u_if.udp_tx_ack = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [63:0] mk_word(input int base, input int idx);
        return {base[15:0], 16'hC0DE, idx[31:0]};
    endfunction

    task automatic clear_mon();
        exp_q.delete(); expv_q.delete(); expf_q.delete();
        got_d.delete(); got_v.delete(); got_f.delete();
        port_q.delete(); sof_cyc_q.delete(); eof_cyc_q.delete();
        tx_count = 0;
        hold_err = 0;
    endtask

    // n words; non-last words carry a junk keep that must be ignored.
    task automatic drive_frame(input int n, input logic [7:0] keep, input int base,
                               input int chg_at, input logic [15:0] chg_port);
        bit ok;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = mk_word(base, i);
            s_last  = (i == n - 1);
            s_keep  = (i == n - 1) ? keep : 8'h3C;
            if (i == chg_at) cfg_dest_port_no = chg_port;
            ok = 1'b0;
            for (int w = 0; w < 2000 && !ok; w++) begin
                @(negedge clk);
                ok = s_ready;
                @(posedge clk);
                #1;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL drive_word%0d got no s_ready want accept", i);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic expect_frame(input int base, input int start, input int n, input logic [7:0] keep);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk_word(base, start + i));
            expv_q.push_back((i == n - 1) ? keep : 8'hFF);
            expf_q.push_back({i == 0, i == n - 1});
        end
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int w = 0; w < 1000 && !idle; w++) begin
            @(negedge clk);
            idle = !busy;
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL %s_idle got busy=1 want busy=0", name);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl got ready=%b busy=%b st=%0d want 1 0 0", s_ready, busy, state_dbg);
        end
        checks++;
        if (u_if.udp_tx_data_valid !== 8'h00 || u_if.udp_tx_sof !== 1'b0 || u_if.udp_tx_eof !== 1'b0 ||
            u_if.udp_tx_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_tx got v=%h sof=%b eof=%b d=%h want 0", u_if.udp_tx_data_valid,
                     u_if.udp_tx_sof, u_if.udp_tx_eof, u_if.udp_tx_data);
        end
        checks++;
        if (frames_sent !== 32'd0 || frames_dropped !== 32'd0 || u_if.udp_tx_dest_port_no !== 16'd0 ||
            u_if.udp_tx_dest_ip_addr !== 128'd0) begin
            errors++;
            $display("FAIL reset_cnt got sent=%0d drop=%0d port=%h want 0", frames_sent, frames_dropped,
                     u_if.udp_tx_dest_port_no);
        end
    endtask

    task automatic test_basic();
        clear_mon();
        expect_frame(1, 0, 3, 8'hC0);
        drive_frame(3, 8'hC0, 1, -1, 16'h0);
        @(negedge clk);
        checks++;
        if (u_if.udp_tx_data_valid !== 8'h00 || s_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_lat1 got v=%h ready=%b busy=%b want 00 0 1", u_if.udp_tx_data_valid, s_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (u_if.udp_tx_data_valid !== 8'hFF || u_if.udp_tx_sof !== 1'b1 || u_if.udp_tx_data !== mk_word(1, 0)) begin
            errors++;
            $display("FAIL basic_lat2 got v=%h sof=%b d=%h want FF 1 %h", u_if.udp_tx_data_valid,
                     u_if.udp_tx_sof, u_if.udp_tx_data, mk_word(1, 0));
        end
        wait_idle("basic");
        exp_sent++;
        checks++;
        if (s_ready !== 1'b1 || cyc != ack_cyc + 1) begin
            errors++;
            $display("FAIL basic_ack_ready got ready=%b cyc=%0d want 1 at %0d", s_ready, cyc, ack_cyc + 1);
        end
        checks++;
        if (got_d.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_count got %0d want %0d", got_d.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_v[i] !== expv_q[i] || got_f[i] !== expf_q[i]) begin
                errors++;
                $display("FAIL basic_word%0d got %h/%h/%b want %h/%h/%b", i, got_d[i], got_v[i], got_f[i],
                         exp_q[i], expv_q[i], expf_q[i]);
            end
        end
        checks++;
        if (frames_sent !== 32'(exp_sent) || frames_dropped !== 32'd0) begin
            errors++;
            $display("FAIL basic_sent got %0d/%0d want %0d/0", frames_sent, frames_dropped, exp_sent);
        end
        checks++;
        if (u_if.udp_tx_dest_ip_addr !== cfg_dest_ip_addr || u_if.udp_tx_dest_ipv4_6n !== 1'b1 ||
            u_if.udp_tx_dest_port_no !== 16'h1234 || u_if.udp_tx_source_port_no !== 16'h5678) begin
            errors++;
            $display("FAIL basic_hdr got port=%h src=%h v4=%b want 1234 5678 1", u_if.udp_tx_dest_port_no,
                     u_if.udp_tx_source_port_no, u_if.udp_tx_dest_ipv4_6n);
        end
    endtask

    task automatic test_cts_toggle();
        clear_mon();
        cts_idx = 0;
        cts_toggle = 1'b1;
        expect_frame(2, 0, 3, 8'hC0);
        drive_frame(3, 8'hC0, 2, -1, 16'h0);
        wait_idle("cts");
        cts_toggle = 1'b0;
        exp_sent++;
        checks++;
        if (got_d.size() != exp_q.size() || hold_err != 0) begin
            errors++;
            $display("FAIL cts_count got %0d words hold_err=%0d want %0d 0", got_d.size(), hold_err, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_v[i] !== expv_q[i] || got_f[i] !== expf_q[i]) begin
                errors++;
                $display("FAIL cts_word%0d got %h/%h/%b want %h/%h/%b", i, got_d[i], got_v[i], got_f[i],
                         exp_q[i], expv_q[i], expf_q[i]);
            end
        end
        checks++;
        if (frames_sent !== 32'(exp_sent)) begin
            errors++;
            $display("FAIL cts_sent got %0d want %0d", frames_sent, exp_sent);
        end
    endtask

    task automatic test_nak_retry();
        clear_mon();
        naks_left = 2;
        for (int k = 0; k < 3; k++) expect_frame(3, 0, 4, 8'hFC);
        drive_frame(4, 8'hFC, 3, -1, 16'h0);
        wait_idle("nak");
        exp_sent++;
        checks++;
        if (tx_count != 3 || got_d.size() != exp_q.size()) begin
            errors++;
            $display("FAIL nak_tx got %0d tx %0d words want 3 tx %0d words", tx_count, got_d.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_v[i] !== expv_q[i] || got_f[i] !== expf_q[i]) begin
                errors++;
                $display("FAIL nak_word%0d got %h/%h/%b want %h/%h/%b", i, got_d[i], got_v[i], got_f[i],
                         exp_q[i], expv_q[i], expf_q[i]);
            end
        end
        checks++;
        if (frames_sent !== 32'(exp_sent) || frames_dropped !== 32'(exp_dropped)) begin
            errors++;
            $display("FAIL nak_cnt got %0d/%0d want %0d/%0d", frames_sent, frames_dropped, exp_sent, exp_dropped);
        end
    endtask

    task automatic test_drop();
        clear_mon();
        naks_left = 4;
        for (int k = 0; k < 4; k++) expect_frame(4, 0, 2, 8'h80);
        drive_frame(2, 8'h80, 4, -1, 16'h0);
        wait_idle("drop");
        exp_dropped++;
        checks++;
        if (tx_count != 4 || got_d.size() != exp_q.size()) begin
            errors++;
            $display("FAIL drop_tx got %0d tx %0d words want 4 tx %0d words", tx_count, got_d.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_v[i] !== expv_q[i] || got_f[i] !== expf_q[i]) begin
                errors++;
                $display("FAIL drop_word%0d got %h/%h/%b want %h/%h/%b", i, got_d[i], got_v[i], got_f[i],
                         exp_q[i], expv_q[i], expf_q[i]);
            end
        end
        checks++;
        if (frames_dropped !== 32'(exp_dropped) || frames_sent !== 32'(exp_sent) || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_cnt got drop=%0d sent=%0d ready=%b want %0d %0d 1", frames_dropped, frames_sent,
                     s_ready, exp_dropped, exp_sent);
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        silent_left = 1;
        drive_frame(1, 8'hE0, 5, -1, 16'h0);
        wait_idle("timeout");
        exp_sent++;
        checks++;
        if (tx_count != 2 || sof_cyc_q.size() != 2 || eof_cyc_q.size() != 2) begin
            errors++;
            $display("FAIL timeout_tx got %0d tx want 2", tx_count);
        end else begin
            // eof in cycle c, WAIT_ACK timer 0..40 over c+1..c+41, SEND c+42, word at c+43
            checks++;
            if (sof_cyc_q[1] - eof_cyc_q[0] != ACK_TIMEOUT + 3) begin
                errors++;
                $display("FAIL timeout_gap got %0d want %0d", sof_cyc_q[1] - eof_cyc_q[0], ACK_TIMEOUT + 3);
            end
        end
        checks++;
        if (frames_sent !== 32'(exp_sent) || frames_dropped !== 32'(exp_dropped)) begin
            errors++;
            $display("FAIL timeout_cnt got %0d/%0d want %0d/%0d", frames_sent, frames_dropped, exp_sent, exp_dropped);
        end
    endtask

    task automatic test_max_words();
        clear_mon();
        cfg_dest_port_no = 16'h1111;
        expect_frame(7, 0, 128, 8'hFF);
        expect_frame(7, 128, 2, 8'hF8);
        drive_frame(130, 8'hF8, 7, 60, 16'h2222);
        wait_idle("maxw");
        exp_sent += 2;
        checks++;
        if (tx_count != 2 || got_d.size() != exp_q.size()) begin
            errors++;
            $display("FAIL maxw_tx got %0d tx %0d words want 2 tx %0d words", tx_count, got_d.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_v[i] !== expv_q[i] || got_f[i] !== expf_q[i]) begin
                errors++;
                $display("FAIL maxw_word%0d got %h/%h/%b want %h/%h/%b", i, got_d[i], got_v[i], got_f[i],
                         exp_q[i], expv_q[i], expf_q[i]);
            end
        end
        checks++;
        if (port_q.size() != 2) begin
            errors++;
            $display("FAIL maxw_ports got %0d entries want 2", port_q.size());
        end else if (port_q[0] !== 16'h1111 || port_q[1] !== 16'h2222) begin
            errors++;
            $display("FAIL maxw_ports got %h,%h want 1111,2222", port_q[0], port_q[1]);
        end
        checks++;
        if (frames_sent !== 32'(exp_sent)) begin
            errors++;
            $display("FAIL maxw_sent got %0d want %0d", frames_sent, exp_sent);
        end
    endtask

    task automatic test_reset_mid_send();
        bit hit;
        clear_mon();
        drive_frame(10, 8'hFF, 8, -1, 16'h0);
        hit = 1'b0;
        for (int w = 0; w < 100 && !hit; w++) begin
            @(negedge clk);
            hit = (u_if.udp_tx_data_valid != 8'h00) && (u_if.udp_tx_data == mk_word(8, 5));
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_word5 got no word 5 want word 5");
        end
        sync_reset = 1'b1;
        @(posedge clk);
        #1;
        sync_reset = 1'b0;
        exp_sent = 0;
        exp_dropped = 0;
        @(negedge clk);
        checks++;
        if (u_if.udp_tx_data_valid !== 8'h00 || frames_sent !== 32'd0 || frames_dropped !== 32'd0 ||
            s_ready !== 1'b1 || busy !== 1'b0 || u_if.udp_tx_dest_port_no !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid got v=%h sent=%0d drop=%0d ready=%b busy=%b port=%h want 00 0 0 1 0 0000",
                     u_if.udp_tx_data_valid, frames_sent, frames_dropped, s_ready, busy, u_if.udp_tx_dest_port_no);
        end
        clear_mon();
        expect_frame(9, 0, 1, 8'h80);
        drive_frame(1, 8'h80, 9, -1, 16'h0);
        wait_idle("rst1");
        exp_sent++;
        checks++;
        if (got_d.size() != 1) begin
            errors++;
            $display("FAIL rst_one_count got %0d want 1", got_d.size());
        end else if (got_d[0] !== exp_q[0] || got_v[0] !== expv_q[0] || got_f[0] !== 2'b11) begin
            errors++;
            $display("FAIL rst_one_word got %h/%h/%b want %h/%h/11", got_d[0], got_v[0], got_f[0], exp_q[0], expv_q[0]);
        end
        checks++;
        if (frames_sent !== 32'(exp_sent)) begin
            errors++;
            $display("FAIL rst_one_sent got %0d want %0d", frames_sent, exp_sent);
        end
    endtask

    // ---------------- main sequence + report ----------------
    initial begin
        sync_reset         = 1'b1;
        s_data             = 64'd0;
        s_keep             = 8'h00;
        s_valid            = 1'b0;
        s_last             = 1'b0;
        cfg_dest_ip_addr   = 128'h2001_0db8_0000_0000_0000_0000_c0a8_0001;
        cfg_dest_ipv4_6n   = 1'b1;
        cfg_dest_port_no   = 16'h1234;
        cfg_source_port_no = 16'h5678;
        repeat (3) @(posedge clk);
        #1;
        sync_reset = 1'b0;

        test_reset();
        test_basic();
        test_cts_toggle();
        test_nak_retry();
        test_drop();
        test_timeout();
        test_max_words();
        test_reset_mid_send();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
